// File: rtl/rvfi_mem_model.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rvfi_mem_model
// Purpose  : Formal memory responder for riscv-formal core wrappers. Answers
//            a picorv32-style native memory port with a bounded, solver-chosen
//            latency. A small direct-mapped backing store keeps reads coherent
//            with earlier writes. Reads of uncovered locations, and the
//            unwritten bytes of a write miss, take solver free data.
//
// Ports    : clock, reset  - system clock, synchronous active-high reset
//            mem_valid     - core request valid
//            mem_instr     - request is an instruction fetch
//            mem_addr      - byte address (low byte-offset bits ignored)
//            mem_wdata     - write data
//            mem_wstrb     - byte write strobes, 0 = read
//            mem_ready     - one-cycle response strobe per request
//            mem_rdata     - read data, zero whenever mem_ready is low
//            rand_rdata    - solver free data for misses / unwritten bytes
//            rand_delay    - solver latency choice, clamped to MAX_LATENCY
//            busy          - request accepted and not yet answered
//            req_count     - saturating completed-request counter
//
// Options  : RVFI_MEM_MODEL_CHECK_EN - when defined, embedded formal
//            assumptions/assertions on the port protocol are compiled in.
//
// Revision : 1.0 - initial release
// ============================================================================
module rvfi_mem_model #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 8,
    parameter int MAX_LATENCY = 3,
    localparam int LAT_W      = (MAX_LATENCY > 0) ? $clog2(MAX_LATENCY + 1) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mem_valid,
    input  logic                mem_instr,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [XLEN-1:0]     mem_wdata,
    input  logic [XLEN/8-1:0]   mem_wstrb,
    output logic                mem_ready,
    output logic [XLEN-1:0]     mem_rdata,
    input  logic [XLEN-1:0]     rand_rdata,
    input  logic [LAT_W-1:0]    rand_delay,
    output logic                busy,
    output logic [15:0]         req_count
);

    localparam int c_nbytes = XLEN / 8;
    localparam int c_off_w  = (c_nbytes > 1) ? $clog2(c_nbytes) : 0;
    localparam int c_idx_w  = $clog2(DEPTH);
    localparam int c_word_w = ADDR_W - c_off_w;
    localparam int c_tag_w  = c_word_w - c_idx_w;

    localparam logic [LAT_W-1:0] c_max_lat = LAT_W'(MAX_LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t                 r_state_q;
    logic [LAT_W-1:0]       r_cnt_q;
    logic [c_word_w-1:0]    r_addr_q;       // word address only
    logic [XLEN-1:0]        r_wdata_q;
    logic [c_nbytes-1:0]    r_wstrb_q;
    logic                   r_instr_q;
    logic [15:0]            r_req_count_q;
    logic [DEPTH-1:0]       r_valid_q;
    logic [c_tag_w-1:0]     r_tag_q  [DEPTH];
    logic [XLEN-1:0]        r_data_q [DEPTH];

    // ------------------------------------------------------------------------
    // Next-state / combinational datapath
    // ------------------------------------------------------------------------
    state_t                 w_state_d;
    logic [LAT_W-1:0]       w_cnt_d;
    logic [c_word_w-1:0]    w_addr_d;
    logic [XLEN-1:0]        w_wdata_d;
    logic [c_nbytes-1:0]    w_wstrb_d;
    logic                   w_instr_d;
    logic [15:0]            w_req_count_d;
    logic [DEPTH-1:0]       w_valid_d;

    logic [LAT_W-1:0]       w_delay;
    logic [c_idx_w-1:0]     w_idx;
    logic [c_tag_w-1:0]     w_tag;
    logic                   w_hit;
    logic                   w_is_write;
    logic                   w_store_we;
    logic [XLEN-1:0]        w_fill;
    logic [XLEN-1:0]        w_merge;

    // Clamp the solver latency. When the rand_delay range cannot exceed
    // MAX_LATENCY the comparison would be constant, so it is elided.
    if ((2 ** LAT_W - 1) > MAX_LATENCY) begin : g_clamp
        assign w_delay = (rand_delay > c_max_lat) ? c_max_lat : rand_delay;
    end else begin : g_no_clamp
        assign w_delay = rand_delay;
    end

    assign w_idx      = r_addr_q[c_idx_w-1:0];
    assign w_tag      = r_addr_q[c_word_w-1:c_idx_w];
    assign w_hit      = r_valid_q[w_idx] && (r_tag_q[w_idx] == w_tag);
    assign w_is_write = (r_wstrb_q != '0);
    assign w_store_we = (r_state_q == RESP) && w_is_write;

    // w_fill is what a read returns; a write starts from it and overlays
    // the strobed bytes, so a write miss takes free data in the gaps.
    always_comb begin
        w_fill  = w_hit ? r_data_q[w_idx] : rand_rdata;
        w_merge = w_fill;
        for (int i = 0; i < c_nbytes; i++) begin
            if (r_wstrb_q[i]) begin
                w_merge[8*i +: 8] = r_wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_addr_d      = r_addr_q;
        w_wdata_d     = r_wdata_q;
        w_wstrb_d     = r_wstrb_q;
        w_instr_d     = r_instr_q;
        w_req_count_d = r_req_count_q;
        w_valid_d     = r_valid_q;

        case (r_state_q)
            IDLE: begin
                if (mem_valid) begin
                    w_addr_d  = mem_addr[ADDR_W-1:c_off_w];
                    w_wdata_d = mem_wdata;
                    w_wstrb_d = mem_wstrb;
                    w_instr_d = mem_instr;
                    if (w_delay == '0) begin
                        w_state_d = RESP;
                    end else begin
                        // WAIT lasts exactly w_delay cycles: counts down to 0
                        w_state_d = WAIT;
                        w_cnt_d   = w_delay - LAT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (r_cnt_q == '0) begin
                    w_state_d = RESP;
                end else begin
                    w_cnt_d = r_cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                w_state_d = IDLE;
                if (r_req_count_q != 16'hFFFF) begin
                    w_req_count_d = r_req_count_q + 16'd1;
                end
                if (w_store_we) begin
                    w_valid_d[w_idx] = 1'b1;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q     <= IDLE;
            r_cnt_q       <= '0;
            r_addr_q      <= '0;
            r_wdata_q     <= '0;
            r_wstrb_q     <= '0;
            r_instr_q     <= 1'b0;
            r_req_count_q <= '0;
            r_valid_q     <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_addr_q      <= w_addr_d;
            r_wdata_q     <= w_wdata_d;
            r_wstrb_q     <= w_wstrb_d;
            r_instr_q     <= w_instr_d;
            r_req_count_q <= w_req_count_d;
            r_valid_q     <= w_valid_d;
        end
    end

    // Store tag/data carry no reset: the valid bits alone qualify them.
    // A reset landing on the RESP edge still suppresses the update.
    always_ff @(posedge clock) begin
        if (!reset && w_store_we) begin
            r_tag_q[w_idx]  <= w_tag;
            r_data_q[w_idx] <= w_merge;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign mem_ready = (r_state_q == RESP);
    assign mem_rdata = ((r_state_q == RESP) && !w_is_write) ? w_fill : '0;
    assign busy      = (r_state_q != IDLE);
    assign req_count = r_req_count_q;

    // Byte-offset address bits carry no information for a word store.
    if (c_off_w > 0) begin : g_addr_off
        logic w_unused_addr_off;
        assign w_unused_addr_off = ^mem_addr[c_off_w-1:0];
    end

`ifdef RVFI_MEM_MODEL_CHECK_EN
    // ------------------------------------------------------------------------
    // Embedded formal properties, disarmed in the cycle after a reset.
    // ------------------------------------------------------------------------
    logic        r_chk_armed_q;
    logic [31:0] r_age_q;
    logic [31:0] w_age_d;

    // Cycles since acceptance: 1 in the first busy cycle.
    always_comb begin
        w_age_d = r_age_q + 32'd1;
        if ((r_state_q == RESP) || ((r_state_q == IDLE) && !mem_valid)) begin
            w_age_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        r_chk_armed_q <= !reset;
        if (reset) begin
            r_age_q <= '0;
        end else begin
            r_age_q <= w_age_d;
        end
    end

    a_req_stable: assume property (@(posedge clock) disable iff (reset || !r_chk_armed_q)
        busy |-> (mem_valid
                  && (mem_addr[ADDR_W-1:c_off_w] == r_addr_q)
                  && (mem_wdata == r_wdata_q)
                  && (mem_wstrb == r_wstrb_q)
                  && (mem_instr == r_instr_q)));

    a_ready_single: assert property (@(posedge clock) disable iff (reset || !r_chk_armed_q)
        mem_ready |=> !mem_ready);

    a_latency_bound: assert property (@(posedge clock) disable iff (reset || !r_chk_armed_q)
        busy |-> ((r_age_q >= 32'd1) && (r_age_q <= 32'(MAX_LATENCY + 1))));

    a_no_instr_write: assert property (@(posedge clock) disable iff (reset || !r_chk_armed_q)
        (mem_valid && mem_instr) |-> (mem_wstrb == '0));
`else
    logic w_unused_instr;
    assign w_unused_instr = r_instr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rvfi_mem_model.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rvfi_mem_model
// Purpose  : Self-checking bench for rvfi_mem_model (default parameters).
//            A reference model tracks the in-flight request by absolute
//            response cycle and keeps an ideal direct-mapped store; every
//            cycle the DUT outputs are compared against it. Directed
//            transactions with literal expectations pin the model, then a
//            randomized phase drives free requests, data and resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvfi_mem_model;

    localparam int XLEN    = 32;
    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 8;
    localparam int MAX_LAT = 3;
    localparam int LAT_W   = 2;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               mem_valid = 1'b0;
    logic               mem_instr = 1'b0;
    logic [ADDR_W-1:0]  mem_addr = '0;
    logic [XLEN-1:0]    mem_wdata = '0;
    logic [XLEN/8-1:0]  mem_wstrb = '0;
    logic [XLEN-1:0]    rand_rdata = '0;
    logic [LAT_W-1:0]   rand_delay = '0;
    logic               mem_ready;
    logic [XLEN-1:0]    mem_rdata;
    logic               busy;
    logic [15:0]        req_count;

    rvfi_mem_model #(
        .XLEN        (XLEN),
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .MAX_LATENCY (MAX_LAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .rand_rdata (rand_rdata),
        .rand_delay (rand_delay),
        .busy       (busy),
        .req_count  (req_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    endtask

    // ------------------------------------------------------------------------
    // Reference model: one outstanding request answered at an absolute cycle,
    // plus an ideal direct-mapped store indexed by word address.
    // ------------------------------------------------------------------------
    bit          m_inflight;
    int          m_ready_cyc;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    int          m_count;
    bit          st_valid [DEPTH];
    logic [31:0] st_tag   [DEPTH];
    logic [31:0] st_data  [DEPTH];

    initial begin : compare
        int          idx;
        bit          hit;
        bit          exp_ready;
        logic [31:0] base, exp_rdata, newd;
        int          d;
        m_inflight = 0;
        m_count    = 0;
        m_addr     = '0;
        m_wdata    = '0;
        m_wstrb    = '0;
        m_ready_cyc = 0;
        for (int i = 0; i < DEPTH; i++) st_valid[i] = 0;
        forever begin
            @(posedge clock);
            #2;
            idx  = int'((m_addr >> 2) % 32'(DEPTH));
            hit  = st_valid[idx] && (st_tag[idx] == (m_addr >> 5));
            base = hit ? st_data[idx] : rand_rdata;
            exp_ready = m_inflight && (cyc == m_ready_cyc);
            exp_rdata = (exp_ready && m_wstrb == 4'h0) ? base : 32'h0;

            chk("mem_ready", {31'h0, mem_ready}, {31'h0, exp_ready});
            chk("busy",      {31'h0, busy},      {31'h0, m_inflight});
            chk("mem_rdata", mem_rdata, exp_rdata);
            chk("req_count", {16'h0, req_count}, 32'(m_count));

            if (reset) begin
                m_inflight = 0;
                m_count    = 0;
                for (int i = 0; i < DEPTH; i++) st_valid[i] = 0;
            end else if (exp_ready) begin
                if (m_count < 16'hFFFF) m_count++;
                if (m_wstrb != 4'h0) begin
                    for (int b = 0; b < 4; b++)
                        newd[8*b +: 8] = m_wstrb[b] ? m_wdata[8*b +: 8] : base[8*b +: 8];
                    st_valid[idx] = 1;
                    st_tag[idx]   = m_addr >> 5;
                    st_data[idx]  = newd;
                end
                m_inflight = 0;
            end else if (!m_inflight && mem_valid) begin
                d = (int'(rand_delay) > MAX_LAT) ? MAX_LAT : int'(rand_delay);
                m_addr      = mem_addr;
                m_wdata     = mem_wdata;
                m_wstrb     = mem_wstrb;
                m_ready_cyc = cyc + 1 + d;
                m_inflight  = 1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed transaction: hold request one cycle, wait (bounded) for the
    // response, return its data and latency, then step to the idle cycle.
    // ------------------------------------------------------------------------
    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input logic [LAT_W-1:0] dly, input logic [31:0] rr,
                         output logic [31:0] got, output int lat);
        @(posedge clock); #1;
        mem_valid  = 1'b1;
        mem_instr  = 1'b0;
        mem_addr   = a;
        mem_wdata  = wd;
        mem_wstrb  = ws;
        rand_delay = dly;
        rand_rdata = rr;
        got = 'x;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clock); #1;
            mem_valid = 1'b0;
            #2;
            if (mem_ready === 1'b1) begin
                got = mem_rdata;
                lat = k;
                break;
            end
        end
        @(posedge clock); #3;
    endtask

    initial begin : stimulus
        logic [31:0] got;
        int          lat;
        logic [31:0] tags [3];
        tags[0] = 32'h0;
        tags[1] = 32'h1;
        tags[2] = 32'h5A5A5;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        #2;
        chk("reset_ready", {31'h0, mem_ready}, 32'h0);
        chk("reset_busy",  {31'h0, busy},      32'h0);
        chk("reset_count", {16'h0, req_count}, 32'h0);
        chk("reset_rdata", mem_rdata,          32'h0);

        // Read miss, zero delay
        issue(32'h100, 32'h0, 4'h0, 2'd0, 32'hDEADBEEF, got, lat);
        chk("rd_miss_lat",  32'(lat), 32'd1);
        chk("rd_miss_data", got, 32'hDEADBEEF);
        chk("rd_miss_cnt",  {16'h0, req_count}, 32'd1);

        // Full write then read back
        issue(32'h100, 32'h11223344, 4'hF, 2'd0, 32'h99999999, got, lat);
        chk("wr_rdata_zero", got, 32'h0);
        issue(32'h100, 32'h0, 4'h0, 2'd1, 32'h0, got, lat);
        chk("rd_hit_lat",  32'(lat), 32'd2);
        chk("rd_hit_data", got, 32'h11223344);

        // Oversized delay request (7 truncates to the 2-bit maximum)
        issue(32'h10C, 32'h0, 4'h0, LAT_W'(7), 32'h12345678, got, lat);
        chk("max_lat", 32'(lat), 32'd4);
        chk("max_lat_data", got, 32'h12345678);

        // Partial write miss, then read
        issue(32'h104, 32'hAAAABBBB, 4'b0011, 2'd2, 32'hCCCCDDDD, got, lat);
        issue(32'h104, 32'h0, 4'h0, 2'd0, 32'h0, got, lat);
        chk("partial_wr", got, 32'hCCCCBBBB);

        // Same index, different tag: eviction
        issue(32'h000, 32'h01010101, 4'hF, 2'd0, 32'h0, got, lat);
        issue(32'h020, 32'h02020202, 4'hF, 2'd3, 32'h0, got, lat);
        issue(32'h000, 32'h0, 4'h0, 2'd0, 32'h5A5A5A5A, got, lat);
        chk("evict_miss", got, 32'h5A5A5A5A);
        issue(32'h023, 32'h0, 4'h0, 2'd0, 32'hFFFFFFFF, got, lat);
        chk("evict_hit", got, 32'h02020202);

        // Reset while in WAIT
        issue(32'h008, 32'h77777777, 4'hF, 2'd0, 32'h0, got, lat);
        @(posedge clock); #1;
        mem_valid  = 1'b1;
        mem_addr   = 32'h008;
        mem_wstrb  = 4'h0;
        rand_delay = 2'd3;
        @(posedge clock); #1;
        mem_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        #2 chk("busy_pre_reset", {31'h0, busy}, 32'h1);
        @(posedge clock); #1;
        reset = 1'b0;
        #2;
        chk("post_reset_busy",  {31'h0, busy},      32'h0);
        chk("post_reset_ready", {31'h0, mem_ready}, 32'h0);
        chk("post_reset_count", {16'h0, req_count}, 32'h0);
        @(posedge clock); #3;
        chk("dropped_ready", {31'h0, mem_ready}, 32'h0);
        issue(32'h008, 32'h0, 4'h0, 2'd0, 32'h0BADF00D, got, lat);
        chk("post_reset_miss", got, 32'h0BADF00D);
        chk("post_reset_cnt1", {16'h0, req_count}, 32'd1);

        // Randomized phase
        for (int n = 0; n < 4000; n++) begin
            @(posedge clock); #1;
            reset      = ($urandom_range(0, 299) == 0);
            mem_valid  = ($urandom_range(0, 2) != 0);
            mem_addr   = (tags[$urandom_range(0, 2)] << 5) | (32'($urandom_range(0, 7)) << 2)
                         | 32'($urandom_range(0, 3));
            mem_wstrb  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            mem_instr  = (mem_wstrb == 4'h0) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_wdata  = $urandom;
            rand_rdata = $urandom;
            rand_delay = LAT_W'($urandom_range(0, 3));
        end
        @(posedge clock); #1;
        reset     = 1'b0;
        mem_valid = 1'b0;
        repeat (6) @(posedge clock);
        #4;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rvfi_mem_model.md
Name: rvfi_mem_model

Overview:
- Parametrised formal memory responder for the riscv-formal core wrappers.
- Sits between a core's picorv32-style native memory port (mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb/mem_ready/mem_rdata) and the solver's free variables.
- Adds a valid/ready handshake with bounded, solver-chosen latency.
- Adds a small direct-mapped backing store, so reads after writes return coherent data. Uncovered reads return free data.

Parameters:
- XLEN, 32, data width in bits; multiple of 8.
- ADDR_W, 32, address width.
- DEPTH, 8, backing-store entries; power of two, >=2.
- MAX_LATENCY, 3, maximum wait cycles before mem_ready; >=0.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_valid  input  1  core request valid.
- mem_instr  input  1  request is an instruction fetch; a write with mem_instr=1 is illegal.
- mem_addr  input  ADDR_W  byte address; low $clog2(XLEN/8) bits ignored.
- mem_wdata  input  XLEN  write data.
- mem_wstrb  input  XLEN/8  byte write strobes; 0 = read.
- mem_ready  output  1  response strobe, exactly one cycle per request.
- mem_rdata  output  XLEN  read data; valid only while mem_ready=1.
- rand_rdata  input  XLEN  solver free data, used for store misses and for unwritten bytes.
- rand_delay  input  LAT_W  solver latency choice; LAT_W = max(1,$clog2(MAX_LATENCY+1)).
- busy  output  1  request accepted and not yet answered.
- req_count  output  16  completed-request counter; saturates at 16'hFFFF.

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset (clock edge with reset=1): state=IDLE, mem_ready=0, mem_rdata=0, busy=0, req_count=0, all store valid bits cleared. Store data and tags need not be reset.
- Reset overrides everything. A request in flight is dropped, with no store update and no mem_ready.
- IDLE:
  - On mem_valid=1, latch addr, wdata, wstrb and instr.
  - Compute d = min(rand_delay, MAX_LATENCY).
  - d==0 -> RESP; otherwise WAIT with cnt=d-1.
- WAIT: cnt==0 -> RESP; otherwise cnt decrements.
- Latency: a request sampled in IDLE at cycle t gets mem_ready=1 at cycle t+1+d. The minimum is 1 cycle and the maximum is MAX_LATENCY+1.
- busy=1 exactly in WAIT and RESP.
- RESP: mem_ready=1 for one cycle, then unconditional return to IDLE.
  - mem_valid high in the cycle after RESP is treated as a new request.
  - Back-to-back requests are therefore at most one per 2 cycles.
- Store indexing:
  - index = word address bits [$clog2(XLEN/8) +: $clog2(DEPTH)].
  - tag = remaining upper address bits.
  - Each entry holds valid, tag and data.
  - hit = valid && tag matches.
- Read (latched wstrb==0): mem_rdata = stored data on hit, rand_rdata (sampled in the RESP cycle) on miss. The store is unchanged.
- Write (wstrb!=0), applied on the RESP edge:
  - For each byte i with wstrb[i]=1: data byte i = wdata byte i.
  - Non-strobed bytes keep the old data on hit, or take rand_rdata on miss.
  - Entry set valid, tag updated; a miss evicts the previous occupant.
  - mem_rdata = 0 during a write response.
- mem_rdata is 0 in all cycles with mem_ready=0.
- req_count increments on each RESP cycle and saturates at 16'hFFFF.
- Request inputs are sampled only in IDLE. Changes while busy are ignored by the datapath.

Optional Feature:
- Macro: RVFI_MEM_MODEL_CHECK_EN
- When defined, embedded formal properties are enabled, guarded by reset=0 in the previous cycle:
  - assume: mem_valid stays high and addr/wdata/wstrb/instr stay stable from acceptance until mem_ready.
  - assert: mem_ready is never high for 2 consecutive cycles.
  - assert: busy implies mem_ready within MAX_LATENCY+1 cycles of acceptance.
  - assert: no write occurs with mem_instr=1.
- When not defined: no properties and no extra logic; the functional behaviour is identical.

Test Plan:
- Reset, then read 0x100 with rand_delay=0, rand_rdata=32'hDEADBEEF -> mem_ready at t+1, mem_rdata=32'hDEADBEEF, req_count=1.
- Write 0x100 wdata=32'h11223344 wstrb=4'hF, then read 0x100 with rand_rdata=0 -> read returns 32'h11223344.
- rand_delay=7 with MAX_LATENCY=3 -> mem_ready exactly at t+4; busy=1 for cycles t+1..t+4.
- Partial write 0x104 wstrb=4'b0011 wdata=32'hAAAABBBB on a miss with rand_rdata=32'hCCCCDDDD, then read -> 32'hCCCCBBBB.
- DEPTH=8: write 0x000, write 0x020 (same index, different tag), read 0x000 with rand_rdata=32'h5A5A5A5A -> miss returns 32'h5A5A5A5A.
- Assert reset while in WAIT -> next cycle state IDLE, no mem_ready; a subsequent read of a previously written address returns rand_rdata.
